// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner with double-buffered load.
// A new value is staged in a pending register and committed only at a frame boundary.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadReq,
  input  logic [15:0] loadData,
  output logic        loadAck,
  input  logic        lzBlank,
  output logic [3:0]  digitSel,
  output logic [3:0]  bcdOut,
  output logic        blankOut,
  output logic        frameTick
);

  // state | meaning
  // SCAN0 | digit0 (least significant) driven
  // SCAN1 | digit1 driven
  // SCAN2 | digit2 driven
  // SCAN3 | digit3 driven; its last cycle closes the frame
  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_t;

  scan_t       state;
  logic [15:0] prescaler;
  logic [15:0] active;
  logic [15:0] pending;
  logic        pending_valid;
  logic        tc;
  logic        accept;
  logic [3:0]  nibble;
  logic        upper_zero;

  assign tc        = (prescaler == 16'(SCAN_DIV - 1));
  assign frameTick = (state == SCAN3) && tc;
  // An ack cycle never accepts, so a held request is taken every other cycle
  assign accept    = loadReq && !loadAck;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler     <= '0;
      state         <= SCAN0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      loadAck       <= 1'b0;
    end else begin
      prescaler <= tc ? 16'd0 : prescaler + 16'd1;
      if (tc) begin
        case (state)
          SCAN0:   state <= SCAN1;
          SCAN1:   state <= SCAN2;
          SCAN2:   state <= SCAN3;
          default: state <= SCAN0;
        endcase
      end
      loadAck <= accept;
      if (accept) pending <= loadData;
      // Commit uses the value pending before this edge; a same-cycle capture waits a frame
      if (frameTick && pending_valid) active <= pending;
      if (accept)         pending_valid <= 1'b1;
      else if (frameTick) pending_valid <= 1'b0;
    end
  end

  always_comb begin
    digitSel   = 4'b0001;
    nibble     = active[3:0];
    upper_zero = 1'b0;
    case (state)
      SCAN0: begin
        digitSel   = 4'b0001;
        nibble     = active[3:0];
        upper_zero = 1'b0;
      end
      SCAN1: begin
        digitSel   = 4'b0010;
        nibble     = active[7:4];
        upper_zero = (active[15:4] == 12'd0);
      end
      SCAN2: begin
        digitSel   = 4'b0100;
        nibble     = active[11:8];
        upper_zero = (active[15:8] == 8'd0);
      end
      default: begin
        digitSel   = 4'b1000;
        nibble     = active[15:12];
        upper_zero = (active[15:12] == 4'd0);
      end
    endcase
    blankOut = (nibble > 4'd9) || (lzBlank && upper_zero);
    bcdOut   = blankOut ? 4'd0 : nibble;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV = 4): time-indexed reference model
// checked every cycle, plus hand-computed scenario expectations.
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadReq = 1'b0;
  logic [15:0] loadData = 16'd0;
  logic        lzBlank = 1'b0;
  logic        loadAck;
  logic [3:0]  digitSel;
  logic [3:0]  bcdOut;
  logic        blankOut;
  logic        frameTick;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .loadReq(loadReq), .loadData(loadData), .loadAck(loadAck),
    .lzBlank(lzBlank), .digitSel(digitSel), .bcdOut(bcdOut), .blankOut(blankOut),
    .frameTick(frameTick)
  );

  always #5 clk = ~clk;

  // Model: m_t counts cycles since reset; display position follows purely from m_t
  int          m_t = 0;
  logic [15:0] m_active = 16'd0;
  logic [15:0] m_pend = 16'd0;
  logic        m_pv = 1'b0;
  logic        m_ack = 1'b0;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t      <= 0;
      m_active <= 16'd0;
      m_pend   <= 16'd0;
      m_pv     <= 1'b0;
      m_ack    <= 1'b0;
      m_ok     <= 1'b1;
    end else begin
      m_t   <= m_t + 1;
      m_ack <= loadReq && !m_ack;
      if (loadReq && !m_ack) m_pend <= loadData;
      if ((m_t % FRAME == FRAME - 1) && m_pv) m_active <= m_pend;
      if (loadReq && !m_ack) m_pv <= 1'b1;
      else if (m_t % FRAME == FRAME - 1) m_pv <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      int          d;
      logic [15:0] upper;
      logic [3:0]  nib;
      logic        blank;
      d     = (m_t / DIV) % 4;
      upper = m_active >> (4 * d);
      nib   = upper[3:0];
      blank = (nib > 4'd9) || (lzBlank && d != 0 && upper == 16'd0);
      chk("model_digitSel", digitSel, 32'(1 << d));
      chk("model_bcdOut", bcdOut, blank ? 32'd0 : 32'(nib));
      chk("model_blankOut", blankOut, 32'(blank));
      chk("model_frameTick", frameTick, 32'(m_t % FRAME == FRAME - 1));
      chk("model_loadAck", loadAck, 32'(m_ack));
    end
  end

  task automatic at_t(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (m_t != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (m_t != target) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for cycle %0d got %0d", target, m_t);
    end
  endtask

  task automatic pulse_load(input int t, input logic [15:0] d);
    at_t(t - 1);
    @(posedge clk); #1;
    loadReq  = 1'b1;
    loadData = d;
    @(posedge clk); #1;
    loadReq  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle frame after reset
    at_t(0);
    chk("rst_sel", digitSel, 32'h1);
    chk("rst_bcd", bcdOut, 32'h0);
    chk("rst_blank", blankOut, 32'h0);
    chk("rst_tick", frameTick, 32'h0);
    chk("rst_ack", loadAck, 32'h0);
    at_t(4);  chk("idle_sel4", digitSel, 32'h2);
    at_t(8);  chk("idle_sel8", digitSel, 32'h4);
    at_t(12); chk("idle_sel12", digitSel, 32'h8);
    at_t(14); chk("idle_tick14", frameTick, 32'h0);
    at_t(15); chk("idle_tick15", frameTick, 32'h1);
    at_t(16); chk("idle_sel16", digitSel, 32'h1);

    // Load mid-SCAN1, shows up next frame
    pulse_load(21, 16'h1234);
    at_t(22); chk("ld_ack", loadAck, 32'h1);
    at_t(23); chk("ld_ack_drop", loadAck, 32'h0);
    at_t(28); chk("ld_hold", bcdOut, 32'h0);
    at_t(32); chk("ld_d0", bcdOut, 32'h4);
    at_t(36); chk("ld_d1", bcdOut, 32'h3);
    at_t(40); chk("ld_d2", bcdOut, 32'h2);
    at_t(44); chk("ld_d3", bcdOut, 32'h1);

    // Leading-zero blanking
    at_t(49);
    @(posedge clk); #1;
    loadReq = 1'b1; loadData = 16'h0007; lzBlank = 1'b1;
    @(posedge clk); #1;
    loadReq = 1'b0;
    at_t(64); chk("lz_d0_bcd", bcdOut, 32'h7); chk("lz_d0_blank", blankOut, 32'h0);
    at_t(68); chk("lz_d1_blank", blankOut, 32'h1); chk("lz_d1_bcd", bcdOut, 32'h0);
    at_t(72); chk("lz_d2_blank", blankOut, 32'h1);
    at_t(76); chk("lz_d3_blank", blankOut, 32'h1);
    at_t(79);
    @(posedge clk); #1;
    lzBlank = 1'b0;
    at_t(80); chk("nolz_d0", bcdOut, 32'h7);
    at_t(84); chk("nolz_d1_blank", blankOut, 32'h0); chk("nolz_d1_bcd", bcdOut, 32'h0);
    at_t(92); chk("nolz_d3_blank", blankOut, 32'h0);

    // Invalid BCD nibble
    pulse_load(100, 16'h0A05);
    at_t(112); chk("inv_d0", bcdOut, 32'h5); chk("inv_d0_blank", blankOut, 32'h0);
    at_t(116); chk("inv_d1", bcdOut, 32'h0); chk("inv_d1_blank", blankOut, 32'h0);
    at_t(120); chk("inv_d2_blank", blankOut, 32'h1); chk("inv_d2_bcd", bcdOut, 32'h0);
    at_t(124); chk("inv_d3", bcdOut, 32'h0); chk("inv_d3_blank", blankOut, 32'h0);

    // Held request: acks alternate, last value wins
    at_t(137);
    @(posedge clk); #1; loadReq = 1'b1; loadData = 16'h1111;
    @(negedge clk); chk("hold_ack138", loadAck, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("hold_ack139", loadAck, 32'h1);
    @(posedge clk); #1; loadData = 16'h2222;
    @(negedge clk); chk("hold_ack140", loadAck, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("hold_ack141", loadAck, 32'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("hold_ack142", loadAck, 32'h0);
    @(posedge clk); #1; loadReq = 1'b0;
    @(negedge clk); chk("hold_ack143", loadAck, 32'h1);
    at_t(144); chk("hold_win", bcdOut, 32'h2); chk("hold_ack144", loadAck, 32'h0);

    // Acceptance coinciding with frameTick waits one more frame
    pulse_load(150, 16'h4444);
    pulse_load(159, 16'h5555);
    at_t(160); chk("coin_prev", bcdOut, 32'h4);
    at_t(176); chk("coin_next", bcdOut, 32'h5);

    // Reset during SCAN2 with pending value and an unacked acceptance
    pulse_load(182, 16'h6666);
    at_t(184);
    @(posedge clk); #1;
    loadReq = 1'b1; loadData = 16'h7777; rst = 1'b1;
    @(posedge clk); #1;
    loadReq = 1'b0; rst = 1'b0;
    at_t(0);
    chk("rst2_sel", digitSel, 32'h1);
    chk("rst2_ack", loadAck, 32'h0);
    chk("rst2_bcd", bcdOut, 32'h0);
    at_t(16); chk("rst2_nopend", bcdOut, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      loadReq = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++)
        loadData[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) lzBlank = ~lzBlank;
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    loadReq = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
